add_pipe_nbit: RTL and testbench
================================

Name: add_pipe_nbit

Overview:
- Parametrised, pipelined N-bit adder/subtractor; successor to the combinational half-adder cells in Basic_Blocks.
- Operand width is split into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages.
- valid/ready handshake on input and output, full-throughput streaming (one result per cycle) and backpressure.
- Used as the arithmetic datapath primitive for wider blocks that need timing closure at high clock rates.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); CHUNK = WIDTH/STAGES bits per stage.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A (unsigned/two's complement, same bits).
- b  input  WIDTH  operand B.
- cin  input  1  carry in; used only when op=0.
- op  input  1  0 = add (a+b+cin), 1 = subtract (a+~b+1; cin ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow, 0 = borrow.

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all stage valid bits = 0, all data/carry registers = 0, out_valid = 0, sum = 0, cout = 0. in_ready = 1 after reset, since the pipeline is empty.
- Transfer rules:
  - Input transfer occurs on an edge where in_valid && in_ready.
  - Output transfer occurs on an edge where out_valid && out_ready.
- Stage k (0..STAGES-1) on accept:
  - Adds chunk k of a and b' (b' = op ? ~b : b) plus the carry-in, which is cin/op for k=0 or the registered carry of stage k-1.
  - Registers the CHUNK-bit result, the carry, the lower chunks already computed, and the skewed upper operand chunks still to be processed.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (the last stage register is the output). STAGES cycles from in_valid to out_valid.
- Flow control:
  - Per-stage ready: ready_k = !valid_k || ready_{k+1}; the last stage uses out_ready. in_ready = ready_0 (combinational from out_ready).
  - No bubbles are inserted; full throughput when out_ready is held at 1.
  - Max in-flight beats = STAGES.
- Hold: while out_valid && !out_ready, sum and cout are stable.
- Ordering: strict FIFO; no drop, no duplication.
- Simultaneous accept and emit on a full pipeline is legal and keeps the pipeline full.
- Arithmetic: wrap-around modulo 2^WIDTH; cout is the carry out of bit WIDTH-1.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops immediately (asynchronous). No stale result appears after reset release.
- STAGES=1: degenerates to a single registered adder with 1-cycle latency.

Optional Feature:
- Macro: ADD_PIPE_OVF_EN.
- Defined: adds output `ovf` (1 bit), the signed overflow of the final result (carry into MSB XOR carry out). It is registered alongside sum, reset to 0, and held under backpressure.
- Undefined: port `ovf` and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package add_pipe_pkg:
  - op encodings OP_ADD=1'b0, OP_SUB=1'b1.
  - Helper function/constant for CHUNK.
  - Parameter legality check (WIDTH % STAGES == 0).
- Sub-module add_pipe_stage: one CHUNK-wide adder slice with its valid/ready register. Instantiated STAGES times by a generate loop in add_pipe_nbit.

Test Plan (WIDTH=16, STAGES=4):
- Reset asserted then released -> out_valid=0, sum=0x0000, cout=0, in_ready=1.
- Add a=0xFFFF, b=0x0001, cin=0 -> 4 cycles later sum=0x0000, cout=1 (carry crosses all stages); a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
- Subtract a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
- Stream 8 back-to-back random beats with out_ready=1 -> one result per cycle after 4-cycle fill, in order, all matching the reference model.
- out_ready=0 for 6 cycles during a stream -> exactly 4 beats accepted, then in_ready=0, sum held constant. Releasing out_ready -> all beats emerge in order, no loss or duplication.
- rst_n pulsed low between edges with 3 beats in flight -> out_valid=0 immediately; after release, no stale output and in_ready=1. With ADD_PIPE_OVF_EN defined, 0x7FFF+0x0001 -> ovf=1, sum=0x8000.

Source files
------------

// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared encodings and parameter helpers for add_pipe_nbit.
// Rev 1.0
`default_nettype none

package add_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_of(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  function automatic bit params_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_pipe_nbit_if.sv
// add_pipe_nbit_if: operand/result stream bundle for add_pipe_nbit.
// Rev 1.0  (ovf present only with ADD_PIPE_OVF_EN)
`default_nettype none

interface add_pipe_nbit_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADD_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef ADD_PIPE_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef ADD_PIPE_OVF_EN
    , output ovf
`endif
  );

endinterface

`default_nettype wire

// File: rtl/add_pipe_stage.sv
// add_pipe_stage: one CHUNK-wide adder slice with its own valid/ready register.
// Rev 1.0  (ovf_out present only with ADD_PIPE_OVF_EN)
`default_nettype none

module add_pipe_stage #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic [WIDTH-1:0] s_in,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             c_out,
  output logic [WIDTH-1:0] s_out
`ifdef ADD_PIPE_OVF_EN
  , output logic           ovf_out
`endif
);

  logic             r_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_s;
  logic [CHUNK:0]   w_full;
  logic [WIDTH-1:0] w_res_ext;
  logic             w_load;

  // Operands stay right-aligned: each slice consumes the low chunk and shifts
  // the rest down; the result is shifted in from the top so the last stage
  // holds the fully assembled sum.
  assign w_full    = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, c_in};
  assign w_res_ext = WIDTH'(w_full[CHUNK-1:0]);

  assign up_ready = !r_valid || dn_ready;
  assign w_load   = up_valid && up_ready;

`ifdef ADD_PIPE_OVF_EN
  logic r_ovf;
  logic w_ovf;
  // Same-sign operands producing an opposite-sign chunk MSB.
  assign w_ovf   = (a_in[CHUNK-1] ~^ b_in[CHUNK-1]) & (w_full[CHUNK-1] ^ a_in[CHUNK-1]);
  assign ovf_out = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_load) begin
      r_ovf <= w_ovf;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_s     <= '0;
    end else begin
      if (up_ready) begin
        r_valid <= up_valid;
      end
      if (w_load) begin
        r_a <= a_in >> CHUNK;
        r_b <= b_in >> CHUNK;
        r_c <= w_full[CHUNK];
        r_s <= (s_in >> CHUNK) | (w_res_ext << (WIDTH - CHUNK));
      end
    end
  end

  assign dn_valid = r_valid;
  assign a_out    = r_a;
  assign b_out    = r_b;
  assign c_out    = r_c;
  assign s_out    = r_s;

endmodule

`default_nettype wire

// File: rtl/add_pipe_nbit.sv
// add_pipe_nbit: pipelined WIDTH-bit adder/subtractor, STAGES carry-registered slices.
// Rev 1.0  (optional signed-overflow output: ADD_PIPE_OVF_EN)
`default_nettype none

module add_pipe_nbit
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  add_pipe_nbit_if.slave bus
);

  localparam int CHUNK = chunk_of(WIDTH, STAGES);

  if (!params_legal(WIDTH, STAGES)) begin : g_param_check
    $error("add_pipe_nbit: WIDTH must be a positive multiple of STAGES");
  end

  logic [STAGES:0]  w_valid;
  logic [STAGES:0]  w_ready;
  logic [STAGES:0]  w_c;
  logic [WIDTH-1:0] w_a [STAGES+1];
  logic [WIDTH-1:0] w_b [STAGES+1];
  logic [WIDTH-1:0] w_s [STAGES+1];
`ifdef ADD_PIPE_OVF_EN
  logic [STAGES-1:0] w_ovf;
`endif

  // Subtraction folds into stage 0 as a + ~b + 1.
  assign w_valid[0] = bus.in_valid;
  assign w_a[0]     = bus.a;
  assign w_b[0]     = (bus.op == OP_SUB) ? ~bus.b : bus.b;
  assign w_c[0]     = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
  assign w_s[0]     = '0;
  assign bus.in_ready = w_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_pipe_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (w_valid[k]),
      .up_ready (w_ready[k]),
      .a_in     (w_a[k]),
      .b_in     (w_b[k]),
      .c_in     (w_c[k]),
      .s_in     (w_s[k]),
      .dn_valid (w_valid[k+1]),
      .dn_ready (w_ready[k+1]),
      .a_out    (w_a[k+1]),
      .b_out    (w_b[k+1]),
      .c_out    (w_c[k+1]),
      .s_out    (w_s[k+1])
`ifdef ADD_PIPE_OVF_EN
      , .ovf_out (w_ovf[k])
`endif
    );
  end

  assign w_ready[STAGES] = bus.out_ready;
  assign bus.out_valid   = w_valid[STAGES];
  assign bus.sum         = w_s[STAGES];
  assign bus.cout        = w_c[STAGES];

  // Operands are fully consumed by the last slice; only its overflow matters.
  logic unused_tail;
`ifdef ADD_PIPE_OVF_EN
  assign bus.ovf   = w_ovf[STAGES-1];
  assign unused_tail = ^{w_a[STAGES], w_b[STAGES], w_ovf};
`else
  assign unused_tail = ^{w_a[STAGES], w_b[STAGES]};
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_pipe_nbit.sv
// tb_add_pipe_nbit: vector table plus scoreboard bench for add_pipe_nbit (WIDTH=16, STAGES=4).
// Rev 1.0  (ovf checked only with ADD_PIPE_OVF_EN)
`default_nettype none

module tb_add_pipe_nbit;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  add_pipe_nbit_if #(.WIDTH(W)) bus ();

  add_pipe_nbit #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic op);
    logic [W-1:0] bb;
    logic [W:0]   r;
    exp_t         e;
    bb = op ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (op ? 1'b1 : cin)};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  // Output side of the scoreboard: compare on every output transfer.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(bus.sum), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", 32'(bus.sum), 32'(e.sum));
        check("cout", 32'(bus.cout), 32'(e.cout));
`ifdef ADD_PIPE_OVF_EN
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Drive one beat until accepted; expected result is queued on acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic op, input exp_t e, output int tries);
    logic acc;
    acc   = 1'b0;
    tries = 0;
    bus.in_valid = 1'b1;
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    bus.op  = op;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (acc) sb.push_back(e);
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[6];
    exp_t  e;
    int    tries;
    int    lat;
    int    acc_cnt;
    int    stale;
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic [W-1:0] ra, rb;
    logic         rc, rop;

    checks = 0;
    errors = 0;
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'h0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors, one at a time; first one also measures latency.
    for (int i = 0; i < 6; i++) begin
      e.sum  = vecs[i].sum;
      e.cout = vecs[i].cout;
      e.ovf  = vecs[i].ovf;
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, e, tries);
      bus.in_valid = 1'b0;
      if (i == 0) begin
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
          @(posedge clk);
          #1;
          lat++;
        end
        check("latency", 32'(lat), 32'(S - 1));
      end
      wait_drain();
    end

    // Back-to-back random stream at full throughput.
    for (int i = 0; i < 8; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rc  = 1'($urandom);
      rop = 1'($urandom);
      send(ra, rb, rc, rop, model(ra, rb, rc, rop), tries);
      check("stream_one_try", 32'(tries), 32'd1);
    end
    bus.in_valid = 1'b0;
    repeat (S) @(posedge clk);
    #1;
    check("stream_no_bubble", 32'(sb.size()), 32'd0);

    // Backpressure: pipeline fills to S beats and holds its output.
    bus.out_ready = 1'b0;
    acc_cnt   = 0;
    held_sum  = '0;
    held_cout = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rc  = 1'($urandom);
      rop = 1'($urandom);
      bus.in_valid = 1'b1;
      bus.a   = ra;
      bus.b   = rb;
      bus.cin = rc;
      bus.op  = rop;
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(ra, rb, rc, rop));
        acc_cnt++;
      end
      if (i == 4) begin
        held_sum  = bus.sum;
        held_cout = bus.cout;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", 32'(acc_cnt), 32'(S));
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_sum_held", 32'(bus.sum), 32'(held_sum));
    check("bp_cout_held", 32'(bus.cout), 32'(held_cout));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_drain();

    // Asynchronous reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0), tries);
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check("arst_no_stale", 32'(stale), 32'd0);
    check("arst_in_ready_after", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    e.sum  = 16'h0100;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, e, tries);
    bus.in_valid = 1'b0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
